// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter
//   Shares one AXI4-Lite memory slave between instruction fetch (M0, read
//   only) and load/store (M1, read + write). One whole transaction is granted
//   at a time, from address phase through the response handshake.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : on M0/M1 contention the master not granted last wins
//                 (within M1, write beats read)
//     undefined : fixed priority M1 write > M1 read > M0 read
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   m0_ar*/m0_r*          M0 read address / read data channels
//   m1_ar*/m1_r*          M1 read address / read data channels
//   m1_aw*/m1_w*/m1_b*    M1 write address / write data / write response
//   s_*                   mirror of the M1 bundle toward the memory slave
//   m0_grants, m1_grants  32-bit wrapping grant counters
module axi_lite_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  // M0 read
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  // M1 read
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  // M1 write
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  // Slave side
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  // Statistics
  output logic [31:0]         m0_grants,
  output logic [31:0]         m1_grants
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    M0_RD = 2'd1,
    M1_RD = 2'd2,
    M1_WR = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Set once the corresponding handshake has completed in the current grant,
  // so a still-high master valid is not forwarded a second time.
  logic addr_done;
  logic aw_done;
  logic w_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1;
`endif

  always_comb begin
    state_next = state;

    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;

    unique case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        // M1 wins unless M0 is also requesting and M1 had the last grant.
        if ((m1_awvalid || m1_arvalid) && (!m0_arvalid || !last_m1))
          state_next = m1_awvalid ? M1_WR : M1_RD;
        else if (m0_arvalid)
          state_next = M0_RD;
`else
        if (m1_awvalid)
          state_next = M1_WR;
        else if (m1_arvalid)
          state_next = M1_RD;
        else if (m0_arvalid)
          state_next = M0_RD;
`endif
      end

      M0_RD: begin
        s_arvalid  = m0_arvalid & ~addr_done;
        m0_arready = s_arready & ~addr_done;
        s_araddr   = m0_araddr;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        s_rready   = m0_rready;
        if (s_rvalid && m0_rready)
          state_next = IDLE;
      end

      M1_RD: begin
        s_arvalid  = m1_arvalid & ~addr_done;
        m1_arready = s_arready & ~addr_done;
        s_araddr   = m1_araddr;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        s_rready   = m1_rready;
        if (s_rvalid && m1_rready)
          state_next = IDLE;
      end

      M1_WR: begin
        s_awvalid  = m1_awvalid & ~aw_done;
        m1_awready = s_awready & ~aw_done;
        s_awaddr   = m1_awaddr;
        s_wvalid   = m1_wvalid & ~w_done;
        m1_wready  = s_wready & ~w_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        s_bready   = m1_bready;
        if (s_bvalid && m1_bready)
          state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr_done <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      m0_grants <= '0;
      m1_grants <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m1   <= 1'b0;
`endif
    end else begin
      state <= state_next;

      // Flags are cleared during the IDLE cycle that separates grants.
      if (state == IDLE) begin
        addr_done <= 1'b0;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else begin
        if (s_arvalid && s_arready) addr_done <= 1'b1;
        if (s_awvalid && s_awready) aw_done   <= 1'b1;
        if (s_wvalid && s_wready)   w_done    <= 1'b1;
      end

      if (state == IDLE && state_next == M0_RD) begin
        m0_grants <= m0_grants + 32'd1;
`ifdef ARB_ROUND_ROBIN_EN
        last_m1   <= 1'b0;
`endif
      end
      if (state == IDLE && (state_next == M1_RD || state_next == M1_WR)) begin
        m1_grants <= m1_grants + 32'd1;
`ifdef ARB_ROUND_ROBIN_EN
        last_m1   <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Self-checking bench for axi_lite_mem_arbiter. The bench plays both masters
// and the memory slave; a transaction-level model predicts the grant order
// and the grant counters.
module tb_axi_lite_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [1:0]  m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp;
  logic [31:0] m0_grants, m1_grants;

  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .m0_grants(m0_grants), .m1_grants(m1_grants)
  );

  always #5 clock = ~clock;

  // Every handshake output of the arbiter; all must be 0 while idle.
  logic [11:0] hs_outs;
  assign hs_outs = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                    m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  logic pay_any;
  assign pay_any = |{m0_rdata, m0_rresp, m1_rdata, m1_rresp, m1_bresp,
                     s_araddr, s_awaddr, s_wdata, s_wstrb};

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state.
  int unsigned exp_m0 = 0;
  int unsigned exp_m1 = 0;
  bit          model_last_m1 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pending set: bit0 = M0 read, bit1 = M1 read, bit2 = M1 write.
  function automatic int pick(input logic [2:0] p);
`ifdef ARB_ROUND_ROBIN_EN
    if ((p[2] || p[1]) && (!p[0] || !model_last_m1))
      return p[2] ? 2 : 1;
    return 0;
`else
    if (p[2]) return 2;
    if (p[1]) return 1;
    return 0;
`endif
  endfunction

  task automatic idle_checks();
    #1;
    check("idle_hs", hs_outs, 0);
    check("idle_pay", pay_any, 0);
  endtask

  // Entered on the first negedge of the granted state; returns on the negedge
  // of the IDLE cycle after completion. The master keeps arvalid high for the
  // whole transaction so that the one-shot address gating is exercised.
  task automatic do_read(input bit is_m1, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] resp);
    int unsigned ar_dly = $urandom_range(0, 3);
    int unsigned r_dly  = $urandom_range(0, 3);
    int unsigned rr_dly = $urandom_range(0, 2);
    int unsigned cyc = 0, r_cyc = 0;
    bit ar_hs = 0, ar_now, done = 0;
    check("rd_grant", {s_arvalid, s_awvalid, s_wvalid}, 3'b100);
    while (!done && cyc < 64) begin
      s_arready = !ar_hs && cyc >= ar_dly;
      s_rvalid  = ar_hs && r_cyc >= r_dly;
      s_rdata   = s_rvalid ? data : $urandom;
      s_rresp   = s_rvalid ? resp : 2'b00;
      if (is_m1) m1_rready = ar_hs && r_cyc >= rr_dly;
      else       m0_rready = ar_hs && r_cyc >= rr_dly;
      #1;
      if (ar_hs) check("ar_gated", s_arvalid, 0);
      ar_now = s_arvalid && s_arready;
      if (ar_now) begin
        check("araddr", s_araddr, addr);
        check("ar_route", is_m1 ? {m1_arready, m0_arready} : {m0_arready, m1_arready}, 2'b10);
      end
      if (s_rvalid && s_rready) begin
        check("rdata", is_m1 ? m1_rdata : m0_rdata, data);
        check("rresp", is_m1 ? m1_rresp : m0_rresp, resp);
        check("r_route", is_m1 ? {m1_rvalid, m0_rvalid} : {m0_rvalid, m1_rvalid}, 2'b10);
        done = 1;
      end
      if (ar_hs) r_cyc++;
      if (ar_now) ar_hs = 1;
      @(negedge clock);
      cyc++;
    end
    if (!done) check("rd_timeout", 0, 1);
    s_arready = 0; s_rvalid = 0; s_rresp = 0; s_rdata = 32'hFFFF_FFFF;
    m0_rready = 0; m1_rready = 0;
    if (is_m1) m1_arvalid = 0; else m0_arvalid = 0;
    idle_checks();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    int unsigned aw_dly = $urandom_range(0, 3);
    int unsigned w_dly  = $urandom_range(0, 3);
    int unsigned b_dly  = $urandom_range(0, 2);
    int unsigned br_dly = $urandom_range(0, 2);
    int unsigned cyc = 0, b_cyc = 0;
    bit aw_hs = 0, w_hs = 0, aw_now, w_now, done = 0;
    check("wr_grant", {s_arvalid, s_awvalid, s_wvalid}, 3'b011);
    while (!done && cyc < 64) begin
      s_awready = !aw_hs && cyc >= aw_dly;
      s_wready  = !w_hs && cyc >= w_dly;
      s_bvalid  = aw_hs && w_hs && b_cyc >= b_dly;
      s_bresp   = s_bvalid ? resp : 2'b00;
      m1_bready = aw_hs && w_hs && b_cyc >= br_dly;
      #1;
      if (aw_hs) check("aw_gated", s_awvalid, 0);
      if (w_hs)  check("w_gated", s_wvalid, 0);
      if (aw_hs && w_hs && !s_bvalid) check("b_early", m1_bvalid, 0);
      aw_now = s_awvalid && s_awready;
      w_now  = s_wvalid && s_wready;
      if (aw_now) begin
        check("awaddr", s_awaddr, addr);
        check("awready", m1_awready, 1);
      end
      if (w_now) begin
        check("wdata", {s_wstrb, s_wdata}, {strb, data});
        check("wready", m1_wready, 1);
      end
      if (s_bvalid && s_bready) begin
        check("bresp", {m1_bvalid, m1_bresp}, {1'b1, resp});
        done = 1;
      end
      if (aw_hs && w_hs) b_cyc++;
      if (aw_now) aw_hs = 1;
      if (w_now)  w_hs = 1;
      if (aw_hs && w_hs) begin
        m1_awvalid = 0;
        m1_wvalid  = 0;
      end
      @(negedge clock);
      cyc++;
    end
    if (!done) check("wr_timeout", 0, 1);
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    m1_bready = 0; m1_awvalid = 0; m1_wvalid = 0;
    idle_checks();
  endtask

  // Raises all requested transactions in the same IDLE cycle and serves them
  // in the order the model predicts.
  task automatic run_round(input logic [2:0] req,
                           input logic [31:0] a0, input logic [31:0] d0, input logic [1:0] r0,
                           input logic [31:0] a1, input logic [31:0] d1, input logic [1:0] r1,
                           input logic [31:0] aw, input logic [31:0] dw, input logic [3:0] sw,
                           input logic [1:0] rw);
    logic [2:0] pend = req;
    int k;
    m0_arvalid = req[0]; m0_araddr = a0;
    m1_arvalid = req[1]; m1_araddr = a1;
    m1_awvalid = req[2]; m1_wvalid = req[2];
    m1_awaddr = aw; m1_wdata = dw; m1_wstrb = sw;
    @(negedge clock);
    while (pend != 0) begin
      k = pick(pend);
      model_last_m1 = (k != 0);
      if (k == 0) exp_m0++; else exp_m1++;
      case (k)
        0: do_read(1'b0, a0, d0, r0);
        1: do_read(1'b1, a1, d1, r1);
        default: do_write(aw, dw, sw, rw);
      endcase
      pend[k] = 1'b0;
      if (pend != 0) @(negedge clock);
    end
    check("m0_grants", m0_grants, exp_m0);
    check("m1_grants", m1_grants, exp_m1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    {m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
    {m0_araddr, m1_araddr, m1_awaddr, m1_wdata, m1_wstrb} = '0;
    {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '0;
    {s_rdata, s_rresp, s_bresp} = '0;
    repeat (2) @(negedge clock);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("rst_idle", hs_outs, 0);
    end
    check("rst_grants", {m0_grants, m1_grants}, 0);

    // Plain M0 fetch.
    run_round(3'b001, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // M0 read racing an M1 write.
    run_round(3'b101, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00, 0, 0, 0,
              32'h8000_0100, 32'h1234_5678, 4'b0011, 2'b00);
    // M1 read with an error response, then an M0 read.
    run_round(3'b010, 0, 0, 0, 32'h8000_0200, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 0);
    run_round(3'b001, 32'h8000_0004, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] req = 3'($urandom_range(1, 7));
      run_round(req, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom),
                $urandom, $urandom, 4'($urandom), 2'($urandom));
    end

    // Reset while M1_RD waits for its address handshake.
    m1_arvalid = 1; m1_araddr = $urandom;
    @(negedge clock);
    check("rst_mid_grant", s_arvalid, 1);
    reset = 1;
    @(negedge clock);
    #1;
    check("rst_mid_hs", hs_outs, 0);
    check("rst_mid_grants", {m0_grants, m1_grants}, 0);
    m1_arvalid = 0;
    reset = 0;
    exp_m0 = 0; exp_m1 = 0; model_last_m1 = 0;
    @(negedge clock);
    check("rst_mid_idle", hs_outs, 0);
    run_round(3'b011, 32'h8000_0010, 32'h5555_AAAA, 2'b00, 32'h8000_0020, 32'hAAAA_5555, 2'b01,
              0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
